// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan driver.
//   HEX_GLYPH : active-low {dp,g,f,e,d,c,b,a} glyphs for 0..F (dp bit off)
//   SEG_OFF   : all segments dark
//   scan_state_e : scan phase (digit shown / anti-ghosting gap)
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Entry n is the glyph for hex digit n.
   localparam logic [15:0][7:0] HEX_GLYPH = {
      8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
      8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
      8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
      8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
   };

   typedef enum logic [0:0] {
      SHOW = 1'b0,
      GAP  = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to seven-segment glyph.
//   nib_i   : hex digit to show
//   dp_i    : decimal point, 1 = lit
//   blank_i : 1 = darken segments a..g (dp still follows dp_i)
//   segs_o  : active-low {dp,g,f,e,d,c,b,a}
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] segs_o
);

   logic [7:0] glyph;

   assign glyph  = HEX_GLYPH[nib_i];
   assign segs_o = {~dp_i, blank_i ? 7'h7F : glyph[6:0]};

endmodule

// File: rtl/disp_scan.sv
// disp_scan: multiplexed seven-segment display driver.
//   sys_clk / sys_rst : clock, synchronous active-low reset
//   value_i, dp_i     : hex value (nibble k -> digit k) and decimal points
//   load              : strobe capturing value_i/dp_i into the shadow register
//   blank_lz          : leading-zero blanking enable
//   segs              : active-low {dp,g,f,e,d,c,b,a}
//   digs              : one-hot active-high digit enable
//   frame             : pulse in the first cycle digit 0 is driven
//   applied           : pulse when a pending load becomes the displayed value
module disp_scan
   import seg_pkg::*;
#(
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 100000
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [4*DIGITS-1:0]   value_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic                  load,
   input  logic                  blank_lz,
   output logic [7:0]            segs,
   output logic [DIGITS-1:0]     digs,
   output logic                  frame,
   output logic                  applied
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   scan_state_e         state_q, state_d;
   logic [4*DIGITS-1:0] act_val_q, act_val_d, sh_val_q;
   logic [DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q;
   logic                pend_q, pend_d;
   logic [7:0]          segs_q, segs_d, dec_segs;
   logic [DIGITS-1:0]   digs_q, digs_d;
   logic                frame_q, applied_q;
   logic                tick, apply_ev, blank_d, zero_run;

   assign tick = (cnt_q == CW'(SCAN_DIV - 1));

   // Outputs are registered from next-state values, so the state register
   // holds GAP exactly during the tick cycle: the last cycle of each slot
   // shows the blank gap.
   always_comb begin
      cnt_d   = tick ? '0 : cnt_q + CW'(1);
      state_d = (cnt_d == CW'(SCAN_DIV - 1)) ? GAP : SHOW;
      idx_d   = idx_q;
      if (state_q == GAP)
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
   end

   // Leaving the gap of the last digit is the frame boundary where the
   // shadow value is applied; a load on that same cycle bypasses the shadow.
   assign apply_ev = (state_q == GAP) && (idx_q == IW'(DIGITS - 1));

   always_comb begin
      act_val_d = act_val_q;
      act_dp_d  = act_dp_q;
      pend_d    = pend_q;
      if (apply_ev) begin
         pend_d = 1'b0;
         if (load) begin
            act_val_d = value_i;
            act_dp_d  = dp_i;
         end else if (pend_q) begin
            act_val_d = sh_val_q;
            act_dp_d  = sh_dp_q;
         end
      end else if (load) begin
         pend_d = 1'b1;
      end
   end

   // A digit above 0 is blanked when it and every digit above it are zero
   // and its own decimal point is off.
   always_comb begin
      blank_d  = 1'b0;
      zero_run = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run & (act_val_d[4*k +: 4] == 4'h0);
         if (idx_d == IW'(k))
            blank_d = blank_lz & zero_run & ~act_dp_d[k];
      end
   end

   seg_hex_decode u_dec (
      .nib_i   (act_val_d[{idx_d, 2'b00} +: 4]),
      .dp_i    (act_dp_d[idx_d]),
      .blank_i (blank_d),
      .segs_o  (dec_segs)
   );

   assign segs_d = (state_d == GAP) ? SEG_OFF : dec_segs;
   assign digs_d = (state_d == GAP) ? '0 : (DIGITS'(1) << idx_d);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         state_q   <= SHOW;
         act_val_q <= '0;
         act_dp_q  <= '0;
         sh_val_q  <= '0;
         sh_dp_q   <= '0;
         pend_q    <= 1'b0;
         segs_q    <= HEX_GLYPH[0];
         digs_q    <= DIGITS'(1);
         frame_q   <= 1'b0;
         applied_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         state_q   <= state_d;
         act_val_q <= act_val_d;
         act_dp_q  <= act_dp_d;
         pend_q    <= pend_d;
         if (load) begin
            sh_val_q <= value_i;
            sh_dp_q  <= dp_i;
         end
         segs_q    <= segs_d;
         digs_q    <= digs_d;
         frame_q   <= apply_ev;
         applied_q <= apply_ev & (load | pend_q);
      end
   end

   assign segs    = segs_q;
   assign digs    = digs_q;
   assign frame   = frame_q;
   assign applied = applied_q;

endmodule

// File: tb/tb_disp_scan.sv
module tb_disp_scan;

   localparam int D  = 3;
   localparam int S  = 4;
   localparam int FP = D * S;

   localparam logic [7:0] GLY [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic [11:0] value_i = '0;
   logic [2:0]  dp_i = '0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [7:0]  segs;
   logic [2:0]  digs;
   logic        frame, applied;

   always #5 sys_clk = ~sys_clk;

   disp_scan #(.DIGITS(D), .SCAN_DIV(S)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .value_i  (value_i),
      .dp_i     (dp_i),
      .load     (load),
      .blank_lz (blank_lz),
      .segs     (segs),
      .digs     (digs),
      .frame    (frame),
      .applied  (applied)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: cycles since reset, active/shadow values, pending flag.
   int          t = 0;
   logic [11:0] m_act = '0, m_sh = '0;
   logic [2:0]  m_dpa = '0, m_dps = '0;
   logic        m_pend = 1'b0;
   logic [7:0]  e_segs;
   logic [2:0]  e_digs;
   logic        e_frame, e_app;
   int          app_cnt = 0, frame_cnt = 0, bad_co = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0d", tag, obs, exp, t);
      end
   endtask

   // One clock: advance the model with the inputs presented this cycle,
   // then compare all outputs shortly after the edge.
   task automatic step();
      int p, dg;
      logic [3:0] nib;
      logic dpb, blk;
      @(posedge sys_clk);
      e_app = 1'b0;
      if (!sys_rst) begin
         t = 0; m_act = '0; m_sh = '0; m_dpa = '0; m_dps = '0; m_pend = 1'b0;
      end else begin
         t++;
         if (t % FP == 0) begin
            if (load) begin
               m_act = value_i; m_dpa = dp_i; e_app = 1'b1;
            end else if (m_pend) begin
               m_act = m_sh; m_dpa = m_dps; e_app = 1'b1;
            end
            m_pend = 1'b0;
         end else if (load) begin
            m_sh = value_i; m_dps = dp_i; m_pend = 1'b1;
         end
      end
      p  = t % FP;
      dg = p / S;
      e_frame = (p == 0) && (t > 0);
      nib = 4'(m_act >> (4 * dg));
      dpb = m_dpa[dg];
      blk = blank_lz && (dg != 0) && !dpb && ((m_act >> (4 * dg)) == 12'h0);
      if (p % S == S - 1) begin
         e_digs = 3'b000;
         e_segs = 8'hFF;
      end else begin
         e_digs = 3'(1 << dg);
         e_segs = {~dpb, blk ? 7'h7F : GLY[nib][6:0]};
      end
      #1;
      chk("digs", 32'(digs), 32'(e_digs));
      chk("segs", 32'(segs), 32'(e_segs));
      chk("frame", 32'(frame), 32'(e_frame));
      chk("applied", 32'(applied), 32'(e_app));
      if (applied) app_cnt++;
      if (frame) frame_cnt++;
      if (frame && digs != 3'b001) bad_co++;
   endtask

   task automatic goto_pos(input int pos);
      for (int i = 0; i < FP; i++) begin
         step();
         if (t % FP == pos) return;
      end
      chk("goto_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_load(input logic [11:0] v, input logic [2:0] d);
      value_i = v; dp_i = d; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      int last_f;
      // reset
      sys_rst = 1'b0;
      step(); step();
      chk("rst_digs", 32'(digs), 32'h1);
      chk("rst_segs", 32'(segs), 32'hC0);
      chk("rst_frame", 32'(frame), 32'h0);
      chk("rst_applied", 32'(applied), 32'h0);
      sys_rst = 1'b1;
      goto_pos(3);
      chk("first_gap", 32'(digs), 32'h0);

      // basic load and scan
      app_cnt = 0;
      do_load(12'h1A3, 3'b000);
      goto_pos(0);
      chk("ld_applied", 32'(applied), 32'h1);
      chk("d0_segs", 32'(segs), 32'hB0);
      chk("d0_digs", 32'(digs), 32'h1);
      goto_pos(3);  chk("gap0", 32'(digs), 32'h0);
      goto_pos(4);  chk("d1_segs", 32'(segs), 32'h88); chk("d1_digs", 32'(digs), 32'h2);
      goto_pos(8);  chk("d2_segs", 32'(segs), 32'hF9); chk("d2_digs", 32'(digs), 32'h4);
      goto_pos(0);
      chk("one_applied", 32'(app_cnt), 32'd1);

      // leading-zero blanking
      blank_lz = 1'b1;
      do_load(12'h005, 3'b000);
      goto_pos(0);  chk("lz_d0", 32'(segs), 32'h92);
      goto_pos(4);  chk("lz_d1", 32'(segs), 32'hFF);
      goto_pos(8);  chk("lz_d2", 32'(segs), 32'hFF);
      do_load(12'h005, 3'b010);
      goto_pos(0);
      goto_pos(4);  chk("lz_dp_d1", 32'(segs), 32'h40);
      goto_pos(8);  chk("lz_dp_d2", 32'(segs), 32'hFF);
      blank_lz = 1'b0;

      // several loads in a frame, last one on the apply cycle
      goto_pos(0);
      app_cnt = 0;
      do_load(12'h111, 3'b000);
      goto_pos(5);
      do_load(12'h222, 3'b000);
      goto_pos(11);
      value_i = 12'h333; dp_i = 3'b000; load = 1'b1;
      step();
      load = 1'b0;
      chk("bypass_applied", 32'(applied), 32'h1);
      chk("bypass_d0", 32'(segs), 32'hB0);
      goto_pos(4);  chk("bypass_d1", 32'(segs), 32'hB0);
      goto_pos(0);
      chk("single_applied", 32'(app_cnt), 32'd1);

      // reset mid-frame with a pending load
      do_load(12'h777, 3'b111);
      goto_pos(8);
      chk("pre_rst_digs", 32'(digs), 32'h4);
      sys_rst = 1'b0;
      step();
      chk("mid_rst_digs", 32'(digs), 32'h1);
      chk("mid_rst_segs", 32'(segs), 32'hC0);
      sys_rst = 1'b1;
      app_cnt = 0;
      for (int i = 0; i < 30; i++) step();
      chk("no_apply_after_rst", 32'(app_cnt), 32'd0);

      // frame cadence
      frame_cnt = 0; bad_co = 0; last_f = -1;
      for (int i = 0; i < 36; i++) begin
         step();
         if (frame) begin
            if (last_f >= 0) chk("frame_period", 32'(t - last_f), 32'd12);
            last_f = t;
         end
      end
      chk("frame_count", 32'(frame_cnt), 32'd3);
      chk("frame_digs", 32'(bad_co), 32'd0);

      // randomized traffic
      bad_co = 0;
      for (int i = 0; i < 600; i++) begin
         load     = ($urandom % 6 == 0);
         value_i  = ($urandom % 3 == 0) ? 12'($urandom % 16) : 12'($urandom);
         dp_i     = ($urandom % 2 == 0) ? 3'b000 : 3'($urandom);
         if ($urandom % 20 == 0) blank_lz = ~blank_lz;
         sys_rst  = ($urandom % 150 != 0);
         step();
      end
      load = 1'b0; sys_rst = 1'b1;
      chk("rand_frame_digs", 32'(bad_co), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
